// File: rtl/csr_pkg.sv
// Shared constants for the exception commit path: Ecodes, EsubCode and the
// commit sequencer state encoding.
package csr_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [8:0] ESUBCODE_NONE = '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder for the exception sources of the committing
// instruction: INT > ADEF > INE > SYS > BRK > ALE.
module exc_prio_enc
    import csr_pkg::*;
(
    input  logic       has_int,
    input  logic       exc_adef,
    input  logic       exc_ine,
    input  logic       exc_sys,
    input  logic       exc_brk,
    input  logic       exc_ale,
    output logic       exc_hit,
    output logic [5:0] ecode,
    output logic [8:0] esubcode
);

    always_comb begin
        exc_hit  = has_int | exc_adef | exc_ine | exc_sys | exc_brk | exc_ale;
        esubcode = ESUBCODE_NONE;
        ecode    = ECODE_INT;
        if (has_int) begin
            ecode = ECODE_INT;
        end else if (exc_adef) begin
            ecode = ECODE_ADEF;
        end else if (exc_ine) begin
            ecode = ECODE_INE;
        end else if (exc_sys) begin
            ecode = ECODE_SYS;
        end else if (exc_brk) begin
            ecode = ECODE_BRK;
        end else if (exc_ale) begin
            ecode = ECODE_ALE;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/ERTN commit sequencer: issues the CSR commit pulses, then flushes
// the pipeline and holds a Pre-IF redirect until it is accepted.
module exc_commit_ctrl
    import csr_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int PC_W         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    output logic            wb_accept,
    input  logic [PC_W-1:0] wb_pc,
    input  logic            wb_exc_adef,
    input  logic            wb_exc_ine,
    input  logic            wb_exc_sys,
    input  logic            wb_exc_brk,
    input  logic            wb_exc_ale,
    input  logic            wb_ertn,
    input  logic            has_int,
    input  logic [PC_W-1:0] ex_entry,
    input  logic [PC_W-1:0] er_entry,
    output logic            wb_ex,
    output logic [5:0]      wb_ecode,
    output logic [8:0]      wb_esubcode,
    output logic [PC_W-1:0] ex_pc,
    output logic            ertn_flush,
    output logic            flush_all,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    input  logic            redirect_ready
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("exc_commit_ctrl: FLUSH_CYCLES must be in 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t          state, state_nx;
    logic [3:0]      cnt, cnt_nx;
    logic [PC_W-1:0] target, target_nx;

    logic            commit, take_exc, take_ertn;
    logic            exc_hit;
    logic [5:0]      prio_ecode;
    logic [8:0]      prio_esub;

    exc_prio_enc u_prio (
        .has_int  (has_int),
        .exc_adef (wb_exc_adef),
        .exc_ine  (wb_exc_ine),
        .exc_sys  (wb_exc_sys),
        .exc_brk  (wb_exc_brk),
        .exc_ale  (wb_exc_ale),
        .exc_hit  (exc_hit),
        .ecode    (prio_ecode),
        .esubcode (prio_esub)
    );

    // Commit pulses are combinational so the CSR unit updates on the commit edge.
    assign wb_accept   = (state == IDLE);
    assign commit      = wb_valid & wb_accept & ~reset;
    assign take_exc    = commit & exc_hit;
    assign take_ertn   = commit & wb_ertn & ~exc_hit;

    assign wb_ex       = take_exc;
    assign wb_ecode    = take_exc ? prio_ecode : '0;
    assign wb_esubcode = take_exc ? prio_esub  : '0;
    assign ex_pc       = take_exc ? wb_pc      : '0;
    assign ertn_flush  = take_ertn;
    assign redirect_pc = target;

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        target_nx      = target;
        flush_all      = 1'b0;
        redirect_valid = 1'b0;
        case (state)
            IDLE: begin
                if (take_exc || take_ertn) begin
                    state_nx  = FLUSH;
                    cnt_nx    = CNT_INIT;
                    // Pre-edge entry values: the CSR unit rewrites ERA on this edge.
                    target_nx = take_exc ? ex_entry : er_entry;
                end
            end
            FLUSH: begin
                flush_all = ~reset;
                if (cnt == 4'd0) begin
                    state_nx = REDIRECT;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            REDIRECT: begin
                redirect_valid = ~reset;
                if (redirect_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            target <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            target <= target_nx;
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: FLUSH_CYCLES=1 and =3 instances share stimulus and
// are checked by directed scenarios plus a timestamp-based reference model.
module tb_exc_commit_ctrl;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale;
    logic        wb_ertn;
    logic        has_int;
    logic [31:0] ex_entry, er_entry;
    logic        redirect_ready;

    logic [1:0]       o_accept, o_ex, o_ertn, o_flush, o_rv;
    logic [1:0][5:0]  o_ecode;
    logic [1:0][8:0]  o_esub;
    logic [1:0][31:0] o_expc, o_rpc;

    int tests_run    = 0;
    int tests_failed = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exc_commit_ctrl #(.FLUSH_CYCLES(1), .PC_W(32)) u_fc1 (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_accept(o_accept[0]),
        .wb_pc(wb_pc), .wb_exc_adef(wb_exc_adef), .wb_exc_ine(wb_exc_ine),
        .wb_exc_sys(wb_exc_sys), .wb_exc_brk(wb_exc_brk), .wb_exc_ale(wb_exc_ale),
        .wb_ertn(wb_ertn), .has_int(has_int), .ex_entry(ex_entry), .er_entry(er_entry),
        .wb_ex(o_ex[0]), .wb_ecode(o_ecode[0]), .wb_esubcode(o_esub[0]), .ex_pc(o_expc[0]),
        .ertn_flush(o_ertn[0]), .flush_all(o_flush[0]), .redirect_valid(o_rv[0]),
        .redirect_pc(o_rpc[0]), .redirect_ready(redirect_ready)
    );

    exc_commit_ctrl #(.FLUSH_CYCLES(3), .PC_W(32)) u_fc3 (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_accept(o_accept[1]),
        .wb_pc(wb_pc), .wb_exc_adef(wb_exc_adef), .wb_exc_ine(wb_exc_ine),
        .wb_exc_sys(wb_exc_sys), .wb_exc_brk(wb_exc_brk), .wb_exc_ale(wb_exc_ale),
        .wb_ertn(wb_ertn), .has_int(has_int), .ex_entry(ex_entry), .er_entry(er_entry),
        .wb_ex(o_ex[1]), .wb_ecode(o_ecode[1]), .wb_esubcode(o_esub[1]), .ex_pc(o_expc[1]),
        .ertn_flush(o_ertn[1]), .flush_all(o_flush[1]), .redirect_valid(o_rv[1]),
        .redirect_pc(o_rpc[1]), .redirect_ready(redirect_ready)
    );

    // Reference model: age = cycles since the accepted event edge (-1 when idle).
    // Ages 1..FC are flush cycles, later ages are the redirect hold.
    int          age [2] = '{-1, -1};
    logic [31:0] tgt [2] = '{32'h0, 32'h0};

    function automatic int fc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic any_exc();
        return has_int | wb_exc_adef | wb_exc_ine | wb_exc_sys | wb_exc_brk | wb_exc_ale;
    endfunction

    function automatic logic [5:0] ref_ecode();
        logic [5:0] codes [6];
        logic [5:0] f;
        codes = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
        f = {has_int, wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale};
        for (int i = 0; i < 6; i++) begin
            if (f[5-i]) return codes[i];
        end
        return 6'h00;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                age[k] <= -1;
                tgt[k] <= 32'h0;
            end else if (age[k] < 0) begin
                if (wb_valid && (any_exc() || wb_ertn)) begin
                    age[k] <= 1;
                    tgt[k] <= any_exc() ? ex_entry : er_entry;
                end
            end else if (age[k] > fc(k)) begin
                if (redirect_ready) age[k] <= -1;
            end else begin
                age[k] <= age[k] + 1;
            end
        end
    end

    function automatic logic [83:0] expect_vec(input int k);
        logic idle, cm, e, r, fl, rv;
        idle = (age[k] < 0);
        cm   = idle && wb_valid && !reset;
        e    = cm && any_exc();
        r    = cm && wb_ertn && !any_exc();
        fl   = !reset && (age[k] >= 1) && (age[k] <= fc(k));
        rv   = !reset && (age[k] > fc(k));
        return {idle, e, e ? ref_ecode() : 6'h00, 9'h000, e ? wb_pc : 32'h0, r, fl, rv, tgt[k]};
    endfunction

    function automatic logic [83:0] actual_vec(input int k);
        return {o_accept[k], o_ex[k], o_ecode[k], o_esub[k], o_expc[k],
                o_ertn[k], o_flush[k], o_rv[k], o_rpc[k]};
    endfunction

    task automatic clear_inputs();
        wb_valid = 0; wb_pc = 0; wb_ertn = 0; has_int = 0; redirect_ready = 0;
        wb_exc_adef = 0; wb_exc_ine = 0; wb_exc_sys = 0; wb_exc_brk = 0; wb_exc_ale = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        next();
        reset = 0;
    endtask

    task automatic test_reset();
        logic [83:0] v;
        reset = 1;
        clear_inputs();
        ex_entry = 0; er_entry = 0;
        next();
        reset = 0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            v = actual_vec(k);
            tests_run++;
            if (o_accept[k] !== 1'b1) begin
                tests_failed++; $display("FAIL reset_accept[%0d] got %b want 1", k, o_accept[k]);
            end
            tests_run++;
            if (v[82:0] !== 83'h0) begin
                tests_failed++; $display("FAIL reset_outputs[%0d] got %h want 0", k, v[82:0]);
            end
        end
        next();
    endtask

    task automatic test_syscall();
        wb_valid = 1; wb_exc_sys = 1; wb_pc = 32'h1c000100;
        ex_entry = 32'h1c008000; er_entry = $urandom;
        @(negedge clk);
        tests_run++;
        if ({o_ex[0], o_ecode[0], o_esub[0], o_expc[0], o_ertn[0]} !== {1'b1, 6'h0B, 9'h0, 32'h1c000100, 1'b0}) begin
            tests_failed++;
            $display("FAIL syscall_pulse got ex=%b ecode=%h esub=%h pc=%h ertn=%b want 1/0b/0/1c000100/0",
                     o_ex[0], o_ecode[0], o_esub[0], o_expc[0], o_ertn[0]);
        end
        next();
        clear_inputs();
        @(negedge clk);
        tests_run++;
        if ({o_flush[0], o_rv[0], o_accept[0], o_ex[0]} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL syscall_flush got flush=%b rv=%b accept=%b ex=%b want 1/0/0/0",
                     o_flush[0], o_rv[0], o_accept[0], o_ex[0]);
        end
        next();
        @(negedge clk);
        tests_run++;
        if ({o_flush[0], o_rv[0], o_rpc[0]} !== {2'b01, 32'h1c008000}) begin
            tests_failed++;
            $display("FAIL syscall_redirect got flush=%b rv=%b pc=%h want 0/1/1c008000",
                     o_flush[0], o_rv[0], o_rpc[0]);
        end
        redirect_ready = 1;
        next();
        redirect_ready = 0;
        @(negedge clk);
        tests_run++;
        if ({o_rv[0], o_accept[0]} !== 2'b01) begin
            tests_failed++;
            $display("FAIL syscall_release got rv=%b accept=%b want 0/1", o_rv[0], o_accept[0]);
        end
        next();
        do_reset();
    endtask

    task automatic test_priority();
        logic [5:0] pat  [4];
        logic [5:0] want [4];
        logic [31:0] pc;
        pat  = '{6'b111001, 6'b001100, 6'b000110, 6'b000001};
        want = '{6'h00, 6'h0D, 6'h0B, 6'h09};
        for (int i = 0; i < 4; i++) begin
            pc = $urandom & 32'hffff_fffc;
            wb_valid = 1; wb_pc = pc; ex_entry = $urandom;
            {has_int, wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale} = pat[i];
            @(negedge clk);
            tests_run++;
            if ({o_ex[0], o_ecode[0], o_expc[0]} !== {1'b1, want[i], pc}) begin
                tests_failed++;
                $display("FAIL priority[%0d] got ex=%b ecode=%h pc=%h want 1/%h/%h",
                         i, o_ex[0], o_ecode[0], o_expc[0], want[i], pc);
            end
            next();
            do_reset();
        end
    endtask

    task automatic test_ertn();
        logic [31:0] e;
        ex_entry = $urandom; er_entry = 32'h1c000204;
        wb_valid = 1; wb_ertn = 1; wb_pc = $urandom;
        @(negedge clk);
        tests_run++;
        if ({o_ertn[0], o_ex[0]} !== 2'b10) begin
            tests_failed++; $display("FAIL ertn_pulse got ertn=%b ex=%b want 1/0", o_ertn[0], o_ex[0]);
        end
        next();
        clear_inputs();
        @(negedge clk);
        tests_run++;
        if ({o_ertn[0], o_flush[0]} !== 2'b01) begin
            tests_failed++; $display("FAIL ertn_once got ertn=%b flush=%b want 0/1", o_ertn[0], o_flush[0]);
        end
        next();
        @(negedge clk);
        tests_run++;
        if ({o_rv[0], o_rpc[0]} !== {1'b1, 32'h1c000204}) begin
            tests_failed++; $display("FAIL ertn_target got rv=%b pc=%h want 1/1c000204", o_rv[0], o_rpc[0]);
        end
        do_reset();

        e = $urandom;
        ex_entry = e; er_entry = $urandom;
        wb_valid = 1; wb_ertn = 1; wb_exc_brk = 1; wb_pc = $urandom;
        @(negedge clk);
        tests_run++;
        if ({o_ex[0], o_ecode[0], o_ertn[0]} !== {1'b1, 6'h0C, 1'b0}) begin
            tests_failed++;
            $display("FAIL ertn_brk got ex=%b ecode=%h ertn=%b want 1/0c/0", o_ex[0], o_ecode[0], o_ertn[0]);
        end
        next();
        clear_inputs();
        next();
        @(negedge clk);
        tests_run++;
        if ({o_rv[0], o_rpc[0]} !== {1'b1, e}) begin
            tests_failed++; $display("FAIL ertn_brk_target got rv=%b pc=%h want 1/%h", o_rv[0], o_rpc[0], e);
        end
        do_reset();
    endtask

    task automatic test_busy();
        logic [31:0] e1;
        e1 = $urandom;
        ex_entry = e1; wb_valid = 1; wb_exc_sys = 1; wb_pc = $urandom;
        @(negedge clk);
        tests_run++;
        if (o_ex[0] !== 1'b1) begin
            tests_failed++; $display("FAIL busy_first got ex=%b want 1", o_ex[0]);
        end
        next();
        wb_pc = $urandom; ex_entry = $urandom; redirect_ready = 0;
        @(negedge clk);
        tests_run++;
        if ({o_accept[0], o_ex[0], o_flush[0]} !== 3'b001) begin
            tests_failed++;
            $display("FAIL busy_flush got accept=%b ex=%b flush=%b want 0/0/1", o_accept[0], o_ex[0], o_flush[0]);
        end
        next();
        for (int i = 0; i < 5; i++) begin
            wb_pc = $urandom; ex_entry = $urandom;
            @(negedge clk);
            tests_run++;
            if ({o_rv[0], o_ex[0], o_accept[0], o_rpc[0]} !== {3'b100, e1}) begin
                tests_failed++;
                $display("FAIL busy_hold[%0d] got rv=%b ex=%b accept=%b pc=%h want 1/0/0/%h",
                         i, o_rv[0], o_ex[0], o_accept[0], o_rpc[0], e1);
            end
            next();
        end
        clear_inputs();
        do_reset();
    endtask

    task automatic test_flush3();
        logic [31:0] e;
        int nflush;
        bit got_rv;
        e = $urandom;
        ex_entry = e; wb_valid = 1; wb_exc_sys = 1; wb_pc = $urandom;
        next();
        clear_inputs();
        nflush = 0;
        got_rv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_rv[1] === 1'b1) begin
                got_rv = 1;
                break;
            end
            if (o_flush[1] === 1'b1) nflush++;
            next();
        end
        tests_run++;
        if (!got_rv || nflush != 3 || o_rpc[1] !== e) begin
            tests_failed++;
            $display("FAIL flush3_seq got rv_seen=%0d flush_cycles=%0d pc=%h want 1/3/%h",
                     got_rv, nflush, o_rpc[1], e);
        end
        reset = 1;
        #1;
        tests_run++;
        if ({o_rv[1], o_flush[1]} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_drop got rv=%b flush=%b want 0/0", o_rv[1], o_flush[1]);
        end
        next();
        reset = 0;
        @(negedge clk);
        tests_run++;
        if (actual_vec(1) !== {1'b1, 83'h0}) begin
            tests_failed++; $display("FAIL reset_mid got %h want %h", actual_vec(1), {1'b1, 83'h0});
        end
        next();
    endtask

    task automatic test_int_idle();
        int pulses;
        logic [31:0] pc;
        pulses = 0;
        has_int = 1; wb_valid = 0; wb_pc = $urandom;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_ex !== 2'b00) pulses++;
            next();
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++; $display("FAIL int_no_commit got %0d pulses want 0", pulses);
        end
        pc = $urandom;
        wb_valid = 1; wb_pc = pc;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if ({o_ex[k], o_ecode[k], o_expc[k]} !== {1'b1, 6'h00, pc}) begin
                tests_failed++;
                $display("FAIL int_take[%0d] got ex=%b ecode=%h pc=%h want 1/00/%h",
                         k, o_ex[k], o_ecode[k], o_expc[k], pc);
            end
        end
        next();
        do_reset();
    endtask

    task automatic test_random();
        logic [83:0] act, exp_v;
        for (int c = 0; c < 500; c++) begin
            reset          = ($urandom_range(0, 49) == 0);
            wb_valid       = $urandom_range(0, 1);
            wb_pc          = $urandom;
            wb_exc_adef    = ($urandom_range(0, 7) == 0);
            wb_exc_ine     = ($urandom_range(0, 7) == 0);
            wb_exc_sys     = ($urandom_range(0, 7) == 0);
            wb_exc_brk     = ($urandom_range(0, 7) == 0);
            wb_exc_ale     = ($urandom_range(0, 7) == 0);
            has_int        = ($urandom_range(0, 9) == 0);
            wb_ertn        = ($urandom_range(0, 5) == 0);
            ex_entry       = $urandom;
            er_entry       = $urandom;
            redirect_ready = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                act   = actual_vec(k);
                exp_v = expect_vec(k);
                tests_run++;
                if (act !== exp_v) begin
                    tests_failed++;
                    $display("FAIL random[%0d] inst=%0d got %h want %h", c, k, act, exp_v);
                end
            end
            next();
        end
        reset = 0;
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    initial begin
        reset = 1;
        clear_inputs();
        ex_entry = 0;
        er_entry = 0;
        test_reset();
        test_syscall();
        test_priority();
        test_ertn();
        test_busy();
        test_flush3();
        test_int_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
Exception/ERTN commit sequencer sitting between the WB stage and the CSR unit. Prioritises the exception sources carried by the committing instruction, injects pending interrupts, and issues the one-cycle exception/ertn pulses to the CSR unit. It then runs a flush-then-redirect sequence toward the pipeline and Pre-IF, holding off new commits until the redirect is accepted.

Parameters:
FLUSH_CYCLES, 1, number of cycles flush_all stays high after an event (1..15).
PC_W, 32, PC / entry address width.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
wb_valid  in  1  WB holds a committing instruction this cycle
wb_accept  out  1  controller can take a commit (state IDLE)
wb_pc  in  PC_W  PC of committing instruction
wb_exc_adef  in  1  fetch address error flag
wb_exc_ine  in  1  instruction-not-exist flag
wb_exc_sys  in  1  SYSCALL flag
wb_exc_brk  in  1  BREAK flag
wb_exc_ale  in  1  address-misaligned flag
wb_ertn  in  1  instruction is ERTN
has_int  in  1  pending enabled interrupt, from CSR unit
ex_entry  in  PC_W  exception entry, from CSR unit
er_entry  in  PC_W  ERA, from CSR unit
wb_ex  out  1  exception commit pulse to CSR unit
wb_ecode  out  6  Ecode for CSR unit
wb_esubcode  out  9  EsubCode for CSR unit
ex_pc  out  PC_W  PC written to ERA
ertn_flush  out  1  ertn commit pulse to CSR unit
flush_all  out  1  kill every in-flight instruction
redirect_valid  out  1  Pre-IF redirect request
redirect_pc  out  PC_W  redirect target
redirect_ready  in  1  Pre-IF accepts redirect

Behaviour:
- Reset: state IDLE, counter 0; wb_ex, ertn_flush, flush_all and redirect_valid are 0. wb_ecode, wb_esubcode, redirect_pc and ex_pc reset to 0. wb_accept is 1.
- commit = wb_valid & wb_accept.
- Exception is detected when commit & (has_int | any wb_exc_*).
- Priority and Ecode, highest first: INT 0x00 > ADEF 0x08 > INE 0x0D > SYS 0x0B > BRK 0x0C > ALE 0x09. wb_esubcode is always 0.
- Exception and wb_ertn together: the exception wins and ertn_flush stays 0.
- wb_ex, wb_ecode, wb_esubcode and ex_pc=wb_pc are combinational in the commit cycle. This gives a single-cycle pulse aligned with wb_pc, and the CSR unit updates on the same edge. Outputs are 0 when there is no exception.
- ertn_flush = commit & wb_ertn & ~exception, combinational, one cycle.
- At the same edge, the target is latched: ex_entry for an exception, er_entry for an ertn. The CSR unit rewrites ERA on that edge, so the pre-edge value is used.
- States:
  - IDLE: on exception or ertn -> FLUSH with cnt=FLUSH_CYCLES-1. Otherwise stay.
  - FLUSH: flush_all=1 and wb_accept=0. If cnt==0 -> REDIRECT, else cnt-1.
  - REDIRECT: redirect_valid=1, redirect_pc held stable, flush_all=0, wb_accept=0. On redirect_ready -> IDLE. Otherwise hold with no timeout.
- Event-to-redirect latency: FLUSH_CYCLES+1 cycles after the commit edge. With FLUSH_CYCLES=1, redirect_valid rises 2 cycles after the commit cycle.
- While not in IDLE, wb_valid and all flags are ignored. No pulse is emitted and has_int is not consumed.
- A commit in IDLE with no exception or ertn produces no action.
- has_int is sampled only in a commit cycle; with no valid commit, no interrupt is taken.
- Reset mid-sequence forces IDLE within the same cycle and drops redirect_valid.
- cnt is 4 bits wide; FLUSH_CYCLES=0 is illegal and is caught by an elaboration check.

Decomposition:
- Shared package csr_pkg holds:
  - Ecode constants ECODE_INT/ADEF/ALE/SYS/BRK/INE.
  - The 2-bit state encoding IDLE/FLUSH/REDIRECT.
  - ESUBCODE_NONE.
- Natural sub-module: exc_prio_enc, a purely combinational priority encoder. Inputs are has_int plus the five flags; outputs are exc_hit, ecode[5:0] and esubcode[8:0]. The FSM, counter and target latch remain in the top module.

Test Plan:
- SYSCALL: wb_valid=1, wb_exc_sys=1, wb_pc=0x1c000100, ex_entry=0x1c008000 -> wb_ex=1 with ecode 0x0B and ex_pc 0x1c000100 that cycle. flush_all=1 for one cycle. redirect_valid with redirect_pc 0x1c008000 two cycles later, clearing the cycle after redirect_ready.
- Priority: has_int=1 with adef, ine and ale all set -> ecode 0x00. Then has_int=0 with ine+sys -> 0x0D. Then sys+brk -> 0x0B. Then ale only -> 0x09.
- ERTN: wb_ertn=1, er_entry=0x1c000204 -> ertn_flush one cycle, wb_ex=0, redirect_pc 0x1c000204. ERTN combined with brk -> wb_ex with ecode 0x0C, ertn_flush=0, target ex_entry.
- Busy: a second SYSCALL presented during FLUSH/REDIRECT with redirect_ready held low for 5 cycles -> wb_accept=0 and no second wb_ex. redirect_valid and redirect_pc stay stable all 5 cycles.
- FLUSH_CYCLES=3 -> flush_all high for exactly 3 cycles, then redirect_valid. Reset asserted during REDIRECT -> next cycle IDLE, all outputs 0, wb_accept=1.
- has_int=1 with wb_valid=0 for 10 cycles -> no wb_ex. First valid plain instruction then -> wb_ex with ecode 0x00 and ex_pc equal to that instruction's PC.
